// File: rtl/sram16_mem_responder.sv
// Responder for the 64-bit mem_req/mem_wren/mem_ready interface: each request becomes four 16-bit async SRAM beats.
// Build macro SRAM_RANGE_CHECK_EN rejects addresses beyond the SRAM (no strobes, all-ones read data).
module sram16_mem_responder #(
    parameter int SRAM_AW     = 18,
    parameter int WAIT_STATES = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        mem_address,
    input  logic [63:0]        to_mem,
    output logic [63:0]        from_mem,
    input  logic               mem_req,
    input  logic               mem_wren,
    output logic               mem_ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    localparam int         QW_AW     = SRAM_AW - 2;
    localparam logic [3:0] LAST_WAIT = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         beat, beat_nxt;
    logic [3:0]         wait_cnt, wait_cnt_nxt;
    logic [QW_AW-1:0]   addr_lat, addr_lat_nxt;
    logic               wren_lat, wren_lat_nxt;
    logic [63:0]        wdata_lat, wdata_lat_nxt;
    logic [63:0]        from_mem_nxt;
    logic               mem_ready_nxt;
    logic [SRAM_AW-1:0] sram_addr_nxt;
    logic [15:0]        sram_dq_out_nxt;
    logic               sram_dq_oe_nxt;
    logic               sram_ce_n_nxt;
    logic               sram_oe_n_nxt;
    logic               sram_we_n_nxt;
    logic               sram_lane_n_nxt;
    logic               access_nxt;

`ifdef SRAM_RANGE_CHECK_EN
    logic out_of_range;
    assign out_of_range = (mem_address[31:QW_AW] != '0);
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^mem_address[31:QW_AW];
`endif

    // Sequencing: latch the request, walk four beats, then pulse ready for one cycle.
    always_comb begin
        state_nxt     = state;
        beat_nxt      = beat;
        wait_cnt_nxt  = wait_cnt;
        addr_lat_nxt  = addr_lat;
        wren_lat_nxt  = wren_lat;
        wdata_lat_nxt = wdata_lat;
        from_mem_nxt  = from_mem;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    addr_lat_nxt  = mem_address[QW_AW-1:0];
                    wren_lat_nxt  = mem_wren;
                    wdata_lat_nxt = to_mem;
                    beat_nxt      = 2'd0;
                    wait_cnt_nxt  = 4'd0;
                    state_nxt     = SETUP;
`ifdef SRAM_RANGE_CHECK_EN
                    if (out_of_range) begin
                        state_nxt = DONE;
                        if (!mem_wren) begin
                            from_mem_nxt = '1;
                        end
                    end
`endif
                end
            end
            SETUP: begin
                wait_cnt_nxt = 4'd0;
                state_nxt    = STROBE;
            end
            STROBE: begin
                if (wait_cnt == LAST_WAIT) begin
                    if (!wren_lat) begin
                        from_mem_nxt[{beat, 4'b0000} +: 16] = sram_dq_in;
                    end
                    state_nxt = HOLD;
                end else begin
                    wait_cnt_nxt = wait_cnt + 4'd1;
                end
            end
            HOLD: begin
                if (beat == 2'd3) begin
                    state_nxt = DONE;
                end else begin
                    beat_nxt  = beat + 2'd1;
                    state_nxt = SETUP;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        access_nxt      = (state_nxt == SETUP) || (state_nxt == STROBE) || (state_nxt == HOLD);
        mem_ready_nxt   = (state_nxt == DONE);
        sram_addr_nxt   = sram_addr;
        sram_dq_out_nxt = sram_dq_out;
        sram_dq_oe_nxt  = 1'b0;
        sram_ce_n_nxt   = 1'b1;
        sram_oe_n_nxt   = 1'b1;
        sram_we_n_nxt   = 1'b1;
        sram_lane_n_nxt = 1'b1;
        if (access_nxt) begin
            sram_ce_n_nxt   = 1'b0;
            sram_lane_n_nxt = 1'b0;
            sram_addr_nxt   = {addr_lat_nxt, beat_nxt};
            if (wren_lat_nxt) begin
                sram_dq_oe_nxt  = 1'b1;
                sram_dq_out_nxt = wdata_lat_nxt[{beat_nxt, 4'b0000} +: 16];
                sram_we_n_nxt   = (state_nxt != STROBE);
            end else begin
                sram_oe_n_nxt = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            beat        <= 2'd0;
            wait_cnt    <= 4'd0;
            addr_lat    <= '0;
            wren_lat    <= 1'b0;
            wdata_lat   <= '0;
            from_mem    <= '0;
            mem_ready   <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= 1'b1;
            sram_oe_n   <= 1'b1;
            sram_we_n   <= 1'b1;
            sram_ub_n   <= 1'b1;
            sram_lb_n   <= 1'b1;
        end else begin
            state       <= state_nxt;
            beat        <= beat_nxt;
            wait_cnt    <= wait_cnt_nxt;
            addr_lat    <= addr_lat_nxt;
            wren_lat    <= wren_lat_nxt;
            wdata_lat   <= wdata_lat_nxt;
            from_mem    <= from_mem_nxt;
            mem_ready   <= mem_ready_nxt;
            sram_addr   <= sram_addr_nxt;
            sram_dq_out <= sram_dq_out_nxt;
            sram_dq_oe  <= sram_dq_oe_nxt;
            sram_ce_n   <= sram_ce_n_nxt;
            sram_oe_n   <= sram_oe_n_nxt;
            sram_we_n   <= sram_we_n_nxt;
            sram_ub_n   <= sram_lane_n_nxt;
            sram_lb_n   <= sram_lane_n_nxt;
        end
    end

endmodule
